// File: rtl/hazard_tag_pipe_pkg.sv
// rtl/hazard_tag_pipe_pkg.sv - result-source tags, Tuse sentinel and Tnew lookup shared with forwarding
package hazard_tag_pipe_pkg;

    typedef enum logic [2:0] {
        RES_NW   = 3'd0,
        RES_ALU  = 3'd1,
        RES_DM   = 3'd2,
        RES_PC   = 3'd3,
        RES_MOVZ = 3'd4
    } res_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Cycles, counted from entry to E, until the result is available for forwarding.
    function automatic logic [1:0] tnew_init(input logic [2:0] res);
        case (res)
            RES_ALU: tnew_init = 2'd1;
            RES_DM:  tnew_init = 2'd2;
            default: tnew_init = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_tag_pipe_md_busy_counter.sv
// rtl/hazard_tag_pipe_md_busy_counter.sv - mult/div busy countdown loaded when a mult/div leaves E
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [3:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - carries A3/Res/Tnew through E, M, W and computes the D-stage stall
module hazard_tag_pipe
    import hazard_tag_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] A3_D,
    input  logic [2:0] Res_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic       md_busy,
    output logic [4:0] rs_E,
    output logic [4:0] rt_E,
    output logic [4:0] rt_M,
    output logic [4:0] A3_E,
    output logic [4:0] A3_M,
    output logic [4:0] A3_W,
    output logic [2:0] Res_E,
    output logic [2:0] Res_M,
    output logic [2:0] Res_W
);

    logic [4:0] rs_e_d, rs_e_q, rt_e_d, rt_e_q, a3_e_d, a3_e_q;
    logic [2:0] res_e_d, res_e_q;
    logic [1:0] tnew_e_d, tnew_e_q;
    logic       md_start_e_d, md_start_e_q, md_div_e_d, md_div_e_q;
    logic [4:0] rt_m_d, rt_m_q, a3_m_d, a3_m_q, a3_w_d, a3_w_q;
    logic [2:0] res_m_d, res_m_q, res_w_d, res_w_q;
    logic [1:0] tnew_m_d, tnew_m_q;
    logic       stall_rs, stall_rt, stall_md;

    // A source register of 0 never waits, which also covers A3 = 0 in E/M.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a3_e, input logic [2:0] res_e,
                                        input logic [1:0] tnew_e, input logic [4:0] a3_m,
                                        input logic [2:0] res_m, input logic [1:0] tnew_m);
        logic hit_e, hit_m;
        hit_e = (a3_e == src) && (res_e != RES_NW) && (tuse < tnew_e);
        hit_m = (a3_m == src) && (res_m != RES_NW) && (tuse < tnew_m);
        src_hazard = (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (md_start_e_q),
        .is_div(md_div_e_q),
        .busy  (md_busy)
    );

    always_comb begin
        stall_rs = src_hazard(rs_D, Tuse_rs_D, a3_e_q, res_e_q, tnew_e_q, a3_m_q, res_m_q, tnew_m_q);
        stall_rt = src_hazard(rt_D, Tuse_rt_D, a3_e_q, res_e_q, tnew_e_q, a3_m_q, res_m_q, tnew_m_q);
        stall_md = md_use_D && (md_start_e_q || md_busy);
        stall    = stall_rs || stall_rt || stall_md;

        rs_e_d       = 5'd0;
        rt_e_d       = 5'd0;
        a3_e_d       = 5'd0;
        res_e_d      = RES_NW;
        tnew_e_d     = 2'd0;
        md_start_e_d = 1'b0;
        md_div_e_d   = 1'b0;
        if (!stall) begin
            rs_e_d       = rs_D;
            rt_e_d       = rt_D;
            a3_e_d       = A3_D;
            res_e_d      = Res_D;
            tnew_e_d     = tnew_init(Res_D);
            md_start_e_d = md_start_D;
            md_div_e_d   = md_div_D;
        end

        rt_m_d   = rt_e_q;
        a3_m_d   = a3_e_q;
        res_m_d  = res_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
        a3_w_d   = a3_m_q;
        res_w_d  = res_m_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_e_q       <= 5'd0;
            rt_e_q       <= 5'd0;
            a3_e_q       <= 5'd0;
            res_e_q      <= RES_NW;
            tnew_e_q     <= 2'd0;
            md_start_e_q <= 1'b0;
            md_div_e_q   <= 1'b0;
            rt_m_q       <= 5'd0;
            a3_m_q       <= 5'd0;
            res_m_q      <= RES_NW;
            tnew_m_q     <= 2'd0;
            a3_w_q       <= 5'd0;
            res_w_q      <= RES_NW;
        end else begin
            rs_e_q       <= rs_e_d;
            rt_e_q       <= rt_e_d;
            a3_e_q       <= a3_e_d;
            res_e_q      <= res_e_d;
            tnew_e_q     <= tnew_e_d;
            md_start_e_q <= md_start_e_d;
            md_div_e_q   <= md_div_e_d;
            rt_m_q       <= rt_m_d;
            a3_m_q       <= a3_m_d;
            res_m_q      <= res_m_d;
            tnew_m_q     <= tnew_m_d;
            a3_w_q       <= a3_w_d;
            res_w_q      <= res_w_d;
        end
    end

    assign rs_E  = rs_e_q;
    assign rt_E  = rt_e_q;
    assign rt_M  = rt_m_q;
    assign A3_E  = a3_e_q;
    assign A3_M  = a3_m_q;
    assign A3_W  = a3_w_q;
    assign Res_E = res_e_q;
    assign Res_M = res_m_q;
    assign Res_W = res_w_q;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb/tb_hazard_tag_pipe.sv - directed stall and tag-propagation vectors for hazard_tag_pipe
module tb_hazard_tag_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, A3_D;
    logic [2:0] Res_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D;
    logic       md_start_D, md_div_D, md_use_D;
    logic       stall, md_busy;
    logic [4:0] rs_E, rt_E, rt_M, A3_E, A3_M, A3_W;
    logic [2:0] Res_E, Res_M, Res_W;

    int n_cmp = 0;
    int n_mis = 0;

    hazard_tag_pipe #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .A3_D(A3_D), .Res_D(Res_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .stall(stall), .md_busy(md_busy),
        .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .Res_E(Res_E), .Res_M(Res_M), .Res_W(Res_W)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                         input logic [2:0] res, input logic [1:0] trs, input logic [1:0] trt,
                         input logic mds, input logic mdd, input logic mdu);
        rs_D = rs; rt_D = rt; A3_D = a3; Res_D = res;
        Tuse_rs_D = trs; Tuse_rt_D = trt;
        md_start_D = mds; md_div_D = mdd; md_use_D = mdu;
        #1;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 5'd0, 3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        int n_stall;
        int n_busy;
        int guard;
        reset = 1'b0;
        nop();
        #12;
        expect_eq("reset_stall", stall, 0);
        expect_eq("reset_busy", md_busy, 0);
        expect_eq("reset_A3_E", A3_E, 0);
        expect_eq("reset_Res_W", Res_W, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // lw $1,0($2) then addu $2,$1,$3
        set_d(5'd2, 5'd0, 5'd1, 3'd2, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        expect_eq("lw_no_stall", stall, 0);
        tick();
        expect_eq("lw_in_E_res", Res_E, 2);
        set_d(5'd1, 5'd3, 5'd2, 3'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        expect_eq("loaduse_stall", stall, 1);
        tick();
        expect_eq("bubble_A3_E", A3_E, 0);
        expect_eq("bubble_Res_E", Res_E, 0);
        expect_eq("lw_A3_M", A3_M, 1);
        expect_eq("loaduse_release", stall, 0);
        tick();
        expect_eq("addu_A3_E", A3_E, 2);
        expect_eq("addu_rs_E", rs_E, 1);
        nop();
        tick();
        expect_eq("addu_rt_M", rt_M, 3);
        drain();

        // lw $1 then beq $1,$0
        set_d(5'd2, 5'd0, 5'd1, 3'd2, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_eq("beq_stall1", stall, 1);
        tick();
        expect_eq("beq_stall2", stall, 1);
        tick();
        expect_eq("beq_release", stall, 0);
        expect_eq("beq_lw_A3_W", A3_W, 1);
        expect_eq("beq_lw_Res_W", Res_W, 2);
        drain();

        // jal then jr $31
        set_d(5'd0, 5'd0, 5'd31, 3'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 5'd0, 3'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        expect_eq("jr_no_stall", stall, 0);
        expect_eq("jal_Res_E", Res_E, 3);
        expect_eq("jal_A3_E", A3_E, 31);
        drain();

        // mult then mflo
        set_d(5'd4, 5'd5, 5'd0, 3'd0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
        expect_eq("mult_no_stall", stall, 0);
        tick();
        set_d(5'd0, 5'd0, 5'd6, 3'd1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
        expect_eq("mflo_first_busy", md_busy, 0);
        n_stall = 0;
        n_busy = 0;
        guard = 0;
        while (stall && guard < 30) begin
            if (md_busy) n_busy++;
            n_stall++;
            guard++;
            tick();
        end
        expect_eq("mult_stall_cycles", n_stall, 6);
        expect_eq("mult_busy_cycles", n_busy, 5);
        expect_eq("mult_busy_done", md_busy, 0);
        tick();
        expect_eq("mflo_A3_E", A3_E, 6);
        drain();

        // div then mfhi, reset on stall cycle 4
        set_d(5'd4, 5'd5, 5'd0, 3'd0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 5'd7, 3'd1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
        expect_eq("div_stall1", stall, 1);
        repeat (3) tick();
        expect_eq("div_stall4", stall, 1);
        expect_eq("div_busy4", md_busy, 1);
        reset = 1'b0;
        #1;
        expect_eq("rst_mid_busy", md_busy, 0);
        expect_eq("rst_mid_stall", stall, 0);
        expect_eq("rst_mid_out", {rs_E, rt_E, rt_M, A3_E, A3_M, A3_W, Res_E, Res_M, Res_W}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_eq("post_rst_stall", stall, 0);
        tick();
        expect_eq("mfhi_A3_E", A3_E, 7);
        drain();

        // writes to $0 and independent registers
        set_d(5'd1, 5'd2, 5'd0, 3'd2, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_eq("zero_reg_no_stall", stall, 0);
        tick();
        set_d(5'd1, 5'd2, 5'd7, 3'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd2, 5'd8, 3'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd9, 5'd10, 5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_eq("indep_no_stall", stall, 0);
        set_d(5'd7, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_eq("alu_in_M_no_stall", stall, 0);
        set_d(5'd8, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_eq("alu_in_E_stall", stall, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hazard_tag_pipe.md
# hazard_tag_pipe

Producer side of the P6 hazard interface: carries each instruction's destination register, result-source tag and remaining-latency (Tnew) count from D through E, M and W. Its registered tags feed the forwarding mux selection logic. It also computes the D-stage stall from Tuse/Tnew comparison and from a multi-cycle mult/div busy counter. It sits beside the D/E, E/M and M/W pipeline registers and replaces their hazard-related fields.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- rs_D, rt_D  in  5 each  source registers of the D instruction
- A3_D  in  5  destination register of the D instruction (0 = none)
- Res_D  in  3  result source: NW=0, ALU=1, DM=2, PC=3, MOVZ=4
- Tuse_rs_D, Tuse_rt_D  in  2 each  cycles until operand needed; 3 = unused
- md_start_D  in  1  D instruction is mult/div
- md_div_D  in  1  with md_start_D: divide (else multiply)
- md_use_D  in  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- stall  out  1  hold PC and the D register; insert a bubble into E
- md_busy  out  1  mult/div counter nonzero
- rs_E, rt_E, rt_M  out  5 each  registered source fields
- A3_E, A3_M, A3_W  out  5 each  registered destinations
- Res_E, Res_M, Res_W  out  3 each  registered result tags

## Operation
- Initial Tnew at entry to E, derived from Res_D:
  - ALU: 1
  - DM: 2
  - PC: 0
  - MOVZ: 0
  - NW: 0
- Tnew advances as Tnew_M = (Tnew_E == 0) ? 0 : Tnew_E − 1. W has Tnew 0 implicitly.
- stall_rs: rs_D ≠ 0 and either:
  - A3_E == rs_D, Res_E ≠ NW, and Tuse_rs_D < Tnew_E; or
  - A3_M == rs_D, Res_M ≠ NW, and Tuse_rs_D < Tnew_M.
- stall_rt: the same rule using rt_D and Tuse_rt_D.
- stall_md: md_use_D && (md_start_E || md_busy).
- stall = stall_rs | stall_rt | stall_md. This is combinational from the D inputs and the registered state.
- On each clk edge:
  - If stall: the E stage loads a bubble (rs/rt/A3 = 0, Res = NW, Tnew = 0, md_start_E = 0).
  - Else: the E stage loads the D fields.
  - M always loads E and W always loads M; no stall reaches beyond E.
- Mult/div counter cnt, 4 bits:
  - If md_start_E: cnt ← md_div_E ? DIV_CYCLES : MULT_CYCLES.
  - Else if cnt ≠ 0: cnt ← cnt − 1.
  - md_busy = (cnt ≠ 0).
- A second mult/div in D while one is in E or busy stalls through md_use_D. md_start_E and a nonzero cnt therefore never coincide.
- A3 = 0 is never a hazard, whatever the Res tag.

## Timing
- Reset (reset low, asynchronous): every stage register goes to 0, Res_* = NW, Tnew = 0 and cnt = 0. stall = 0 and md_busy = 0 while in reset.
- Latency: a D field appears on the _E outputs 1 edge after it is accepted, _M after 2 edges and _W after 3.
- Load-use (lw then dependent ALU op, Tuse = 1): exactly 1 stall cycle.
- Load then beq (Tuse = 0): 2 stall cycles.
- ALU result then beq: 1 stall cycle.
- mfhi directly after mult: stalled for 1 cycle (start in E) plus MULT_CYCLES busy cycles = 6 cycles. It issues in the cycle after cnt reaches 0.
- Reset asserted mid-operation clears cnt immediately; no stall persists after release.

## Structure
- A shared package holds:
  - the Res encodings NW/ALU/DM/PC/MOVZ, common with the forwarding unit;
  - the Tuse "unused" value 3;
  - the Tnew lookup.
- One sub-module, md_busy_counter: parameters MULT_CYCLES and DIV_CYCLES; ports clk, reset, start, is_div, busy.

## Test plan
- lw $1 then addu $2,$1,$3 (Tuse_rs = 1): stall = 1 for one cycle. A3_E = 0 and Res_E = NW in the bubble. addu reaches E next with A3_E = 2.
- lw $1 then beq $1,$0 (Tuse = 0): stall held for 2 cycles. Released once lw is in W (A3_W = 1, Res_W = DM).
- jal (Res = PC, A3 = 31) then jr $31 (Tuse = 0): no stall. Res_E = PC with Tnew 0.
- mult, then mflo next: stall for 6 consecutive cycles. md_busy high for 5 of them, starting the cycle after mult is in E.
- div then mfhi: 11 stall cycles. Asserting reset on stall cycle 4 drops md_busy and stall at once, and all _E/_M/_W outputs read 0.
- addu $0,... then use of $0: never stalls. Independent registers in E/M: stall stays 0.
